scan_sequencer_3to8: RTL and testbench

Registered scan sequencer that drives the enable and 3-bit select inputs of the 3-to-8 decoder stage directly downstream. On a start command it walks the select from 0 to 7. Each index stays enabled for a programmable dwell time, and optional blanking cycles (enable low) separate one index from the next. Typical uses are LED/keypad row scanning and one-hot strobe generation through the decoder.

---
 rtl/scan_sequencer_3to8_pkg.sv | 24 ++
 rtl/scan_dwell_timer.sv | 40 ++++
 rtl/scan_sequencer_3to8.sv | 155 +++++++++++++++
 tb/tb_scan_sequencer_3to8.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_3to8_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
// State encodings and sweep-mode values are used by the top-level FSM.
package scan_sequencer_3to8_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } scan_state_e;

  localparam logic       MODE_SINGLE = 1'b0;
  localparam logic       MODE_CONT   = 1'b1;
  localparam logic [2:0] IDX_LAST    = 3'd7;

  // Blank timer reload value; a zero blank count never loads the timer.
  function automatic logic [3:0] blank_load_value(input int unsigned cycles);
    if (cycles == 0) begin
      return 4'd0;
    end else begin
      return 4'(cycles - 1);
    end
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter: load has priority over tick, and expire fires on
// a ticked cycle while the count sits at zero.
module scan_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, decrement toward zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer_3to8.sv
// Scan sequencer driving the enable and select of a downstream 3-to-8 decoder.
// Walks select 0..7 with a programmable dwell and fixed blanking between indices.
module scan_sequencer_3to8
  import scan_sequencer_3to8_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic               MODE,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               EN,
  output logic [2:0]         I,
  output logic               BUSY,
  output logic               DONE
);

  localparam logic [3:0] BLANK_LOAD = blank_load_value(BLANK_CYCLES);
  localparam logic       HAS_BLANK  = (BLANK_CYCLES != 0);

  scan_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic               dwell_load;
  logic               blank_load;
  logic               dwell_expire;
  logic               blank_expire;
  logic [DWELL_W-1:0] dwell_value;

  // A programmed dwell of zero behaves as one cycle.
  assign dwell_value = (DWELL == '0) ? '0 : (DWELL - {{(DWELL_W-1){1'b0}}, 1'b1});

  scan_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (dwell_load),
    .value_i  (dwell_value),
    .tick_i   (state_q == S_ACTIVE),
    .expire_o (dwell_expire)
  );

  scan_dwell_timer #(.W(4)) u_blank (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (blank_load),
    .value_i  (BLANK_LOAD),
    .tick_i   (state_q == S_BLANK),
    .expire_o (blank_expire)
  );

  // Next state, index and output values; outputs are registered below.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    en_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    dwell_load = 1'b0;
    blank_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        if (START && !STOP) begin
          state_d    = S_ACTIVE;
          mode_d     = MODE;
          dwell_load = 1'b1;
          en_d       = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        if (STOP) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (dwell_expire) begin
          if ((idx_q == IDX_LAST) && (mode_q == MODE_SINGLE)) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!HAS_BLANK) begin
            idx_d      = idx_q + 3'd1;
            dwell_load = 1'b1;
          end else begin
            state_d    = S_BLANK;
            blank_load = 1'b1;
            en_d       = 1'b0;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_BLANK: begin
        busy_d = 1'b1;
        if (STOP) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          busy_d  = 1'b0;
        end else if (blank_expire) begin
          // Index wraps 7 -> 0 naturally in continuous mode.
          state_d    = S_ACTIVE;
          idx_d      = idx_q + 3'd1;
          dwell_load = 1'b1;
          en_d       = 1'b1;
        end else begin
          state_d = S_BLANK;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State, index, latched mode and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      mode_q  <= MODE_SINGLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign EN   = en_q;
  assign I    = idx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_scan_sequencer_3to8.sv
// Directed bench for scan_sequencer_3to8: one instance with one blank cycle,
// one with none, both driven from the same stimulus.
module tb_scan_sequencer_3to8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       STOP;
  logic       MODE;
  logic [7:0] DWELL;

  logic       en1, busy1, done1;
  logic [2:0] i1;
  logic       en0, busy0, done0;
  logic [2:0] i0;

  int vectors = 0;
  int miscompares = 0;

  scan_sequencer_3to8 #(.DWELL_W(8), .BLANK_CYCLES(1)) dut_b1 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE), .DWELL(DWELL),
    .EN(en1), .I(i1), .BUSY(busy1), .DONE(done1)
  );

  scan_sequencer_3to8 #(.DWELL_W(8), .BLANK_CYCLES(0)) dut_b0 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE), .DWELL(DWELL),
    .EN(en0), .I(i0), .BUSY(busy0), .DONE(done0)
  );

  always #5 CLK = ~CLK;

  wire [5:0] st1 = {en1, i1, busy1, done1};
  wire [5:0] st0 = {en0, i0, busy0, done0};
  wire [7:0] dec0 = en0 ? (8'h01 << i0) : 8'h00;

  function automatic logic [5:0] ex(input logic en, input logic [2:0] idx,
                                    input logic busy, input logic done);
    return {en, idx, busy, done};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b1; STOP = 1'b0; MODE = 1'b0; DWELL = 8'd3;

    // Reset held with START high
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("rst_b1_%0d", n), 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
      check($sformatf("rst_b0_%0d", n), 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    end
    RST = 1'b0; START = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("idle_b1_%0d", n), 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    end

    // Single sweep, DWELL=3, one blank cycle; START mid-scan is ignored
    DWELL = 8'd3; MODE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("sweep_act_k%0d_c%0d", k, c), 32'(st1), 32'(ex(1'b1, 3'(k), 1'b1, 1'b0)));
        if (k == 2 && c == 1) START = 1'b1;
        tick();
        START = 1'b0;
      end
      if (k < 7) begin
        check($sformatf("sweep_blank_k%0d", k), 32'(st1), 32'(ex(1'b0, 3'(k), 1'b1, 1'b0)));
        tick();
      end
    end
    check("sweep_done", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b1)));
    tick();
    check("sweep_after_done", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    check("b0_idle_before_fast", 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));

    // DWELL=0 with no blanking: one cycle per index, EN continuously high
    DWELL = 8'd0; MODE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fast_state_k%0d", k), 32'(st0), 32'(ex(1'b1, 3'(k), 1'b1, 1'b0)));
      check($sformatf("fast_decode_k%0d", k), 32'(dec0), 32'(8'h01 << k));
      tick();
    end
    check("fast_done", 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b1)));
    for (int n = 0; n < 8; n++) tick();
    check("b1_idle_after_fast", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));

    // Continuous mode, DWELL=2, 20 indices then STOP during index 3
    DWELL = 8'd2; MODE = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int n = 0; n < 20; n++) begin
      check($sformatf("cont_act0_n%0d", n), 32'(st1), 32'(ex(1'b1, 3'(n % 8), 1'b1, 1'b0)));
      if (n == 19) begin
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        check("cont_stop", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
      end else begin
        tick();
        check($sformatf("cont_act1_n%0d", n), 32'(st1), 32'(ex(1'b1, 3'(n % 8), 1'b1, 1'b0)));
        tick();
        check($sformatf("cont_blank_n%0d", n), 32'(st1), 32'(ex(1'b0, 3'(n % 8), 1'b1, 1'b0)));
        tick();
      end
    end
    check("cont_b0_stopped", 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));

    // START and STOP together in IDLE
    MODE = 1'b0; START = 1'b1; STOP = 1'b1;
    tick();
    check("startstop_b1", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    check("startstop_b0", 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    START = 1'b0; STOP = 1'b0;
    tick();
    check("startstop_hold", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));

    // RST in the middle of index 5
    DWELL = 8'd3; MODE = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    check("rst_mid_idx5", 32'(st1), 32'(ex(1'b1, 3'd5, 1'b1, 1'b0)));
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_b1", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    check("rst_mid_b0", 32'(st0), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));
    tick();
    check("rst_mid_after", 32'(st1), 32'(ex(1'b0, 3'd0, 1'b0, 1'b0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
